fsm_dispatcher: RTL and testbench

- Top-level sequencer of the Control Unit.
- Fetches each instruction and classifies the one-hot `code` vector from the opdecoder.
- Hands control to exactly one class sub-FSM (ALU, load/store, branch/jump, float) with a one-cycle `start`, waits for its `done`, then retires the instruction and counts it.
- Classification failures and hung sub-FSMs are converted into a sticky trap.

---
 rtl/cu_pkg.sv | 38 +++
 rtl/dispatch_class_decoder.sv | 37 +++
 rtl/fsm_dispatcher.sv | 175 +++++++++++++++++
 tb/tb_fsm_dispatcher.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Brief    : Shared Control Unit types: sequencer states, instruction classes,
//            trap cause codes and default class masks.
// Revision : 1.0 - initial release
// ============================================================================
package cu_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        LATCH    = 3'd2,
        DECODE   = 3'd3,
        DISPATCH = 3'd4,
        WAIT     = 3'd5,
        TRAP     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LDST = 2'd1,
        CLS_BJ   = 2'd2,
        CLS_FP   = 2'd3
    } cls_e;

    localparam logic [1:0] C_CAUSE_NONE    = 2'b00;
    localparam logic [1:0] C_CAUSE_NOCLASS = 2'b01;
    localparam logic [1:0] C_CAUSE_MULTI   = 2'b10;
    localparam logic [1:0] C_CAUSE_WDT     = 2'b11;

    localparam logic [31:0] C_ALU_MASK  = 32'h0000_00FF;
    localparam logic [31:0] C_LDST_MASK = 32'h0000_FF00;
    localparam logic [31:0] C_BJ_MASK   = 32'h0300_0000;
    localparam logic [31:0] C_FP_MASK   = 32'h00FF_0000;

endpackage
`default_nettype wire

// File: rtl/dispatch_class_decoder.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_class_decoder
// Brief    : Combinational classifier of the one-hot opdecoder vector into one
//            instruction class, with no-class / multi-class flags.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_class_decoder
    import cu_pkg::*;
(
    input  logic [31:0] code,
    input  logic [31:0] alu_mask,
    input  logic [31:0] ldst_mask,
    input  logic [31:0] bj_mask,
    input  logic [31:0] fp_mask,
    output cls_e        cls,
    output logic        none,
    output logic        multi
);

    logic [3:0] w_hits;

    assign w_hits = {|(code & fp_mask), |(code & bj_mask),
                     |(code & ldst_mask), |(code & alu_mask)};

    always_comb begin
        none  = (w_hits == 4'd0);
        // More than one bit set: clearing the lowest set bit leaves something.
        multi = ((w_hits & (w_hits - 4'd1)) != 4'd0);
        cls   = CLS_ALU;
        if (w_hits[1]) cls = CLS_LDST;
        if (w_hits[2]) cls = CLS_BJ;
        if (w_hits[3]) cls = CLS_FP;
    end

endmodule
`default_nettype wire

// File: rtl/fsm_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : fsm_dispatcher
// Brief    : Control Unit top sequencer: fetch, classify, dispatch to one class
//            sub-FSM, wait for its done, retire; failures become a sticky trap.
//            Optional WAIT watchdog enabled by macro FSM_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fsm_dispatcher
    import cu_pkg::*;
#(
    parameter logic [31:0] ALU_MASK   = C_ALU_MASK,
    parameter logic [31:0] LDST_MASK  = C_LDST_MASK,
    parameter logic [31:0] BJ_MASK    = C_BJ_MASK,
    parameter logic [31:0] FP_MASK    = C_FP_MASK,
    parameter int          WDT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] code,
    input  logic        mem_ready,
    input  logic        done_alu,
    input  logic        done_ldst,
    input  logic        done_bj,
    input  logic        done_fp,
    input  logic        clear_trap,
    output logic        fetch_req,
    output logic        load_ir,
    output logic        start_alu,
    output logic        start_ldst,
    output logic        start_bj,
    output logic        start_fp,
    output logic        busy,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [63:0] instret
);

    state_e      r_state;
    state_e      w_state_nxt;
    cls_e        r_cls;
    cls_e        w_cls;
    logic        w_none;
    logic        w_multi;
    logic        w_done_sel;
    logic        w_retire;
    logic        w_wdt_expired;
    logic [1:0]  r_trap_cause;
    logic [1:0]  w_trap_cause_nxt;
    logic [63:0] r_instret;

    dispatch_class_decoder u_class_decoder (
        .code      (code),
        .alu_mask  (ALU_MASK),
        .ldst_mask (LDST_MASK),
        .bj_mask   (BJ_MASK),
        .fp_mask   (FP_MASK),
        .cls       (w_cls),
        .none      (w_none),
        .multi     (w_multi)
    );

    // Only the done of the class latched in DECODE can retire the instruction.
    always_comb begin
        w_done_sel = 1'b0;
        case (r_cls)
            CLS_ALU:  w_done_sel = done_alu;
            CLS_LDST: w_done_sel = done_ldst;
            CLS_BJ:   w_done_sel = done_bj;
            CLS_FP:   w_done_sel = done_fp;
            default:  w_done_sel = 1'b0;
        endcase
    end

`ifdef FSM_WATCHDOG_EN
    localparam int C_WDT_W = $clog2(WDT_CYCLES) + 1;

    logic [C_WDT_W-1:0] r_wdt;

    assign w_wdt_expired = (r_wdt == C_WDT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt <= '0;
        end else if (r_state == DISPATCH) begin
            r_wdt <= '0;
        end else if ((r_state == WAIT) && !w_done_sel && !w_wdt_expired) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end
`else
    assign w_wdt_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_trap_cause_nxt = r_trap_cause;
        w_retire         = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (mem_ready) w_state_nxt = LATCH;
            end
            LATCH: begin
                w_state_nxt = DECODE;
            end
            DECODE: begin
                if (w_none) begin
                    w_state_nxt      = TRAP;
                    w_trap_cause_nxt = C_CAUSE_NOCLASS;
                end else if (w_multi) begin
                    w_state_nxt      = TRAP;
                    w_trap_cause_nxt = C_CAUSE_MULTI;
                end else begin
                    w_state_nxt = DISPATCH;
                end
            end
            DISPATCH: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A done arriving on the expiry cycle still retires.
                if (w_done_sel) begin
                    w_retire    = 1'b1;
                    w_state_nxt = run ? FETCH : IDLE;
                end else if (w_wdt_expired) begin
                    w_state_nxt      = TRAP;
                    w_trap_cause_nxt = C_CAUSE_WDT;
                end
            end
            TRAP: begin
                if (clear_trap) begin
                    w_state_nxt      = IDLE;
                    w_trap_cause_nxt = C_CAUSE_NONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cls        <= CLS_ALU;
            r_trap_cause <= C_CAUSE_NONE;
            r_instret    <= 64'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_cause <= w_trap_cause_nxt;
            if (r_state == DECODE) r_cls <= w_cls;
            if (w_retire) r_instret <= r_instret + 64'd1;
        end
    end

    always_comb begin
        fetch_req  = (r_state == FETCH);
        load_ir    = (r_state == LATCH);
        start_alu  = (r_state == DISPATCH) && (r_cls == CLS_ALU);
        start_ldst = (r_state == DISPATCH) && (r_cls == CLS_LDST);
        start_bj   = (r_state == DISPATCH) && (r_cls == CLS_BJ);
        start_fp   = (r_state == DISPATCH) && (r_cls == CLS_FP);
        busy       = (r_state != IDLE) && (r_state != TRAP);
        trap       = (r_state == TRAP);
    end

    assign trap_cause = r_trap_cause;
    assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_fsm_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_dispatcher
// Brief    : Self-checking bench: classification vector table, random
//            transactions against a class/retire scoreboard, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fsm_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] code = 32'd0;
    logic        mem_ready = 1'b0;
    logic        done_alu = 1'b0, done_ldst = 1'b0, done_bj = 1'b0, done_fp = 1'b0;
    logic        clear_trap = 1'b0;
    logic        fetch_req, load_ir, start_alu, start_ldst, start_bj, start_fp;
    logic        busy, trap;
    logic [1:0]  trap_cause;
    logic [63:0] instret;
    logic [3:0]  starts;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_instret = 64'd0;

    fsm_dispatcher #(.WDT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .code       (code),
        .mem_ready  (mem_ready),
        .done_alu   (done_alu),
        .done_ldst  (done_ldst),
        .done_bj    (done_bj),
        .done_fp    (done_fp),
        .clear_trap (clear_trap),
        .fetch_req  (fetch_req),
        .load_ir    (load_ir),
        .start_alu  (start_alu),
        .start_ldst (start_ldst),
        .start_bj   (start_bj),
        .start_fp   (start_fp),
        .busy       (busy),
        .trap       (trap),
        .trap_cause (trap_cause),
        .instret    (instret)
    );

    assign starts = {start_fp, start_bj, start_ldst, start_alu};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 5ms");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference classifier: 0..3 = ALU/LDST/BJ/FP, 4 = no class, 5 = several classes.
    function automatic int model_class(input logic [31:0] c);
        logic [31:0] masks [4];
        int n;
        int k;
        masks[0] = 32'h0000_00FF;
        masks[1] = 32'h0000_FF00;
        masks[2] = 32'h0300_0000;
        masks[3] = 32'h00FF_0000;
        n = 0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if ((c & masks[i]) != 32'd0) begin
                n++;
                k = i;
            end
        end
        if (n == 0) return 4;
        if (n > 1) return 5;
        return k;
    endfunction

    task automatic set_done(input int k, input logic v);
        case (k)
            0: done_alu  = v;
            1: done_ldst = v;
            2: done_bj   = v;
            default: done_fp = v;
        endcase
    endtask

    task automatic clear_dones();
        done_alu = 1'b0; done_ldst = 1'b0; done_bj = 1'b0; done_fp = 1'b0;
    endtask

    // One full instruction transaction, checked against the scoreboard.
    task automatic exec(input logic [31:0] c, input int exp_cls, input int mem_lat,
                        input int done_lat, input bit noise, input bit run_after,
                        input string tag);
        int t;
        int fcyc;
        int extra;
        code = c;
        run  = 1'b1;
        t = 0;
        while (!fetch_req && t < 10) begin
            @(negedge clk);
            t++;
        end
        check({tag, " fetch_req"}, fetch_req, 1);
        fcyc = 0;
        while (fetch_req && fcyc < 20) begin
            fcyc++;
            mem_ready = (fcyc >= mem_lat);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        run = run_after;
        check({tag, " fetch_cycles"}, fcyc, mem_lat);
        check({tag, " load_ir"}, load_ir, 1);
        @(negedge clk);
        check({tag, " load_ir_one_cycle"}, load_ir, 0);
        @(negedge clk);
        if (exp_cls < 4) begin
            check({tag, " start"}, starts, 4'b0001 << exp_cls);
            if (noise) set_done(exp_cls, 1'b1);
            extra = 0;
            for (int p = 1; p <= done_lat; p++) begin
                @(negedge clk);
                clear_dones();
                if (starts != 4'd0) extra++;
                if (noise && p == 1) set_done((exp_cls + 1) % 4, 1'b1);
                if (p == done_lat) begin
                    check({tag, " wait_busy"}, {busy, fetch_req, trap}, 3'b100);
                    check({tag, " instret_before"}, instret, exp_instret);
                    clear_dones();
                    set_done(exp_cls, 1'b1);
                end
            end
            check({tag, " single_start"}, extra, 0);
            @(negedge clk);
            clear_dones();
            exp_instret = exp_instret + 64'd1;
            check({tag, " instret"}, instret, exp_instret);
            if (run_after) check({tag, " next_fetch"}, fetch_req, 1);
            else           check({tag, " idle_after"}, {busy, fetch_req}, 2'b00);
        end else begin
            check({tag, " trap"}, {trap, busy, starts}, {1'b1, 1'b0, 4'b0000});
            check({tag, " trap_cause"}, trap_cause, (exp_cls == 4) ? 2'b01 : 2'b10);
            check({tag, " instret_trap"}, instret, exp_instret);
            @(negedge clk);
            check({tag, " trap_sticky"}, {trap, fetch_req}, 2'b10);
            clear_trap = 1'b1;
            @(negedge clk);
            clear_trap = 1'b0;
            check({tag, " trap_cleared"}, {trap, busy, trap_cause}, 4'b0000);
        end
    endtask

    // Bring the DUT to the DISPATCH cycle for code c (start pulse visible).
    task automatic to_dispatch(input logic [31:0] c, input string tag);
        int t;
        code = c;
        run  = 1'b1;
        t = 0;
        while (!fetch_req && t < 10) begin
            @(negedge clk);
            t++;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        t = 0;
        while (starts == 4'd0 && t < 6) begin
            @(negedge clk);
            t++;
        end
        check({tag, " reached_dispatch"}, (starts != 4'd0), 1);
    endtask

    typedef struct {
        logic [31:0] code;
        int          cls;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{32'h0100_0000, 2};
        vecs[1]  = '{32'h0000_0000, 4};
        vecs[2]  = '{32'h0100_0001, 5};
        vecs[3]  = '{32'h0000_0001, 0};
        vecs[4]  = '{32'h0000_0100, 1};
        vecs[5]  = '{32'h0001_0000, 3};
        vecs[6]  = '{32'h0200_0000, 2};
        vecs[7]  = '{32'h8000_0000, 4};
        vecs[8]  = '{32'h0400_0000, 4};
        vecs[9]  = '{32'h0000_8080, 5};
        vecs[10] = '{32'h0080_0000, 3};
        vecs[11] = '{32'h0000_0080, 0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {fetch_req, load_ir, starts, busy, trap, trap_cause}, 0);
        check("reset_instret", instret, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_run0", {busy, fetch_req}, 2'b00);

        // Branch flow: 2-cycle memory latency, done 3 cycles after start.
        exec(32'h0100_0000, 2, 2, 3, 1'b0, 1'b1, "branch");

        for (int i = 0; i < 12; i++) begin
            exec(vecs[i].code, vecs[i].cls, 1 + (i % 3), 1 + (i % 4), 1'b0, (i % 2) == 1,
                 $sformatf("vec%0d", i));
        end

        // Wrong-class done in WAIT and own done in DISPATCH are both ignored.
        exec(32'h0000_0001, 0, 1, 4, 1'b1, 1'b1, "wrong_done");
        exec(32'h0010_0000, 3, 2, 3, 1'b1, 1'b0, "wrong_done_fp");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] c;
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)      c = 32'd0;
            else if (r < 3)  c = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
            else             c = 32'd1 << $urandom_range(0, 31);
            exec(c, model_class(c), int'($urandom_range(1, 4)), int'($urandom_range(1, 5)),
                 1'b0, $urandom_range(0, 1) == 1, $sformatf("rand%0d", i));
        end

        // Asynchronous reset between clock edges while waiting for done.
        to_dispatch(32'h0000_0001, "areset");
        @(negedge clk);
        check("areset_in_wait", {busy, trap}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("areset_outputs", {fetch_req, load_ir, starts, busy, trap, trap_cause}, 0);
        check("areset_instret", instret, 0);
        exp_instret = 64'd0;
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("areset_stays_idle", {busy, fetch_req, trap}, 3'b000);

`ifdef FSM_WATCHDOG_EN
        to_dispatch(32'h0000_0001, "wdt_trap");
        run = 1'b0;
        repeat (8) @(negedge clk);
        check("wdt_before_expiry", {busy, trap}, 2'b10);
        @(negedge clk);
        check("wdt_trap", {trap, trap_cause}, 3'b111);
        check("wdt_instret", instret, exp_instret);
        clear_trap = 1'b1;
        @(negedge clk);
        clear_trap = 1'b0;
        check("wdt_cleared", {trap, trap_cause}, 3'b000);

        to_dispatch(32'h0000_0001, "wdt_done_wins");
        run = 1'b0;
        repeat (8) @(negedge clk);
        done_alu = 1'b1;
        @(negedge clk);
        done_alu = 1'b0;
        exp_instret = exp_instret + 64'd1;
        check("wdt_done_wins_trap", {trap, busy}, 2'b00);
        check("wdt_done_wins_instret", instret, exp_instret);
`else
        to_dispatch(32'h0000_0001, "no_wdt");
        run = 1'b0;
        repeat (1000) @(negedge clk);
        check("no_wdt_still_wait", {busy, trap, trap_cause}, 4'b1000);
        done_alu = 1'b1;
        @(negedge clk);
        done_alu = 1'b0;
        exp_instret = exp_instret + 64'd1;
        check("no_wdt_retire", instret, exp_instret);
        check("no_wdt_idle", {busy, trap}, 2'b00);
`endif

        // clear_trap outside TRAP has no effect.
        clear_trap = 1'b1;
        @(negedge clk);
        clear_trap = 1'b0;
        check("clear_outside_trap", {busy, trap, trap_cause, instret}, {4'b0000, exp_instret});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
